m_rf_wb_arbiter: RTL and testbench
==================================

// Module: m_rf_wb_arbiter
// PURPOSE
//  Shares the register file's single write port among NREQ write-back requesters (ALU, load, mul/div).
//  Arbitrates round-robin with a valid/ready handshake and drives one registered write per cycle.
//  Keeps a per-register pending scoreboard so decode can detect RAW hazards on its two read addresses.
//  Sits between the execution units and the RF write port (we/wa/wd).
// PARAMETERS
//  NREQ  3   number of write-back requesters (2..8)
//  XLEN  32  data width
//  AW    5   register address width (2**AW registers)
// PORTS
//  w_clk        in   1          clock, rising edge
//  w_rst_n      in   1          asynchronous reset, active low
//  w_req_valid  in   NREQ       requester i has a write pending
//  w_req_ready  out  NREQ       one-hot grant; transfer = valid[i] & ready[i]
//  w_req_addr   in   NREQ*AW    destination register; slice i = [i*AW +: AW]
//  w_req_data   in   NREQ*XLEN  write data; slice i = [i*XLEN +: XLEN]
//  w_iss_valid  in   1          decode issues an instruction with a destination register
//  w_iss_addr   in   AW         that destination register
//  w_ra1        in   AW         hazard query address 1
//  w_ra2        in   AW         hazard query address 2
//  w_hz1        out  1          1 = w_ra1 has an outstanding or in-flight write
//  w_hz2        out  1          1 = w_ra2 has an outstanding or in-flight write
//  w_rf_we      out  1          RF write enable (registered)
//  w_rf_wa      out  AW         RF write address (registered)
//  w_rf_wd      out  XLEN       RF write data (registered)
// BEHAVIOUR
//  Reset: clock is w_clk; reset is w_rst_n, asynchronous, active low.
//   Reset clears we/wa/wd and all pending bits, and sets the RR pointer so req 0 has top priority.
//  Arbitration (combinational):
//   - w_req_ready has at most one bit set, and only for a requester whose valid is high.
//   - Search order starts at (last granted index + 1) mod NREQ.
//  Requester rules: hold valid/addr/data stable until ready. Valid must not drop before the transfer.
//  Pointer: updates only on a transfer, to the granted index. No transfer leaves it unchanged.
//  Write latency: a transfer in cycle t gives we=1 with its wa/wd in cycle t+1.
//   The RF writes at the end of t+1.
//   No transfer in t gives we=0 in t+1; wa/wd hold their previous values.
//  x0: a transfer to addr 0 is accepted (ready asserts) but produces we=0.
//  Throughput: one transfer per cycle; no bubbles under back-to-back requests.
//  Scoreboard (2**AW bits):
//   - w_iss_valid with w_iss_addr!=0 sets pending[w_iss_addr].
//   - A transfer clears pending[addr].
//   - Set and clear on the same address in the same cycle: set wins (a newer producer exists).
//   - Setting an already-pending bit is legal; it stays 1 (one producer in flight per register).
//   - Issue to x0 is ignored; pending[0] is always 0.
//  Hazard (combinational from registered state):
//   - w_hzN = (w_raN!=0) & (pending[w_raN] | (w_rf_we & w_rf_wa==w_raN)).
//   - The in-flight term covers the cycle where the RF is not yet written.
//   - A same-cycle issue does not affect hz until the next cycle.
//  Reset mid-operation: the in-flight write is dropped (we=0) and pending is cleared.
//   Requesters must reissue.
// STRUCTURE
//  Shared package: NREQ/XLEN/AW defaults, REG_ZERO=0, requester index constants (REQ_ALU=0, REQ_LSU=1, REQ_MD=2).
//  Sub-module m_rr_arb: NREQ-wide round-robin arbiter (req, advance -> one-hot gnt, pointer register).
//  Top level: output register, scoreboard, hazard compare.
// TESTING
//  1 Reset: rst_n=0 mid-stream -> we=0, hz1=hz2=0 for every ra, and the next grant goes to req 0.
//  2 Round-robin: valid=3'b111, all held -> ready sequence 001,010,100,001.
//     we=1 every cycle from the 2nd cycle, with wa/wd matching the granted slice one cycle later.
//  3 Scoreboard: issue x5 at t0 -> hz1=1 (ra1=5) from t1.
//     Req1 writes x5 at t3 -> pending clears, hz1 is still 1 at t4 (in flight), hz1=0 at t5.
//  4 Set-wins: issue x7 and transfer to x7 in the same cycle -> pending[7]=1 afterwards.
//     hz stays 1 after the in-flight cycle.
//  5 x0: transfer addr 0, data 32'hDEADBEEF -> ready=1, we=0 next cycle.
//     Issue x0 -> hz for ra=0 is always 0.
//  6 Hold rule: req2 alone, valid held 3 cycles with req0 asserting in cycle 2 -> req2 granted in cycle 1.
//     Req0 is granted in cycle 2, and the pointer advances correctly.

Source files
------------

// File: rtl/m_rf_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter: default sizes,
// the hard-wired zero register and the fixed requester slot assignment.
package m_rf_wb_arbiter_pkg;

  localparam int DEF_NREQ = 3;
  localparam int DEF_XLEN = 32;
  localparam int DEF_AW   = 5;

  localparam int REG_ZERO = 0;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_MD  = 2;

  // Register index 0 is hard-wired zero: never written, never pending.
  function automatic logic f_is_zero_reg(input logic [DEF_AW-1:0] addr);
    return (addr == DEF_AW'(REG_ZERO));
  endfunction

endpackage

// File: rtl/m_rf_wb_arbiter_if.sv
// Bundle of write-back requests, decode issue/hazard queries and the RF write port.
// The master side is the execution units plus decode; the slave side is the arbiter.
interface m_rf_wb_arbiter_if
  import m_rf_wb_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int XLEN = DEF_XLEN,
  parameter int AW   = DEF_AW
);

  logic [NREQ-1:0]      w_req_valid;
  logic [NREQ-1:0]      w_req_ready;
  logic [NREQ*AW-1:0]   w_req_addr;
  logic [NREQ*XLEN-1:0] w_req_data;
  logic                 w_iss_valid;
  logic [AW-1:0]        w_iss_addr;
  logic [AW-1:0]        w_ra1;
  logic [AW-1:0]        w_ra2;
  logic                 w_hz1;
  logic                 w_hz2;
  logic                 w_rf_we;
  logic [AW-1:0]        w_rf_wa;
  logic [XLEN-1:0]      w_rf_wd;

  modport master (
    output w_req_valid, w_req_addr, w_req_data,
    output w_iss_valid, w_iss_addr, w_ra1, w_ra2,
    input  w_req_ready, w_hz1, w_hz2, w_rf_we, w_rf_wa, w_rf_wd
  );

  modport slave (
    input  w_req_valid, w_req_addr, w_req_data,
    input  w_iss_valid, w_iss_addr, w_ra1, w_ra2,
    output w_req_ready, w_hz1, w_hz2, w_rf_we, w_rf_wa, w_rf_wd
  );

endinterface

// File: rtl/m_rf_wb_arbiter_rr_arb.sv
// N-way round-robin arbiter: one-hot grant among active requests, searching from
// the slot after the last granted one; the pointer moves only when told to advance.
module m_rr_arb #(
  parameter  int N  = 3,
  localparam int IW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_advance,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_idx
);

  logic [IW-1:0] r_last;
  logic [IW-1:0] w_cand;
  logic          w_found;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_cand    = '0;
    w_found   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      w_cand = IW'((int'(r_last) + k) % N);
      if (!w_found && i_req[w_cand]) begin
        o_gnt[w_cand] = 1'b1;
        o_gnt_idx     = w_cand;
        w_found       = 1'b1;
      end
    end
  end

  // Reset to the last slot so that slot 0 is searched first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= IW'(N - 1);
    end else if (i_advance) begin
      r_last <= o_gnt_idx;
    end
  end

endmodule

// File: rtl/m_rf_wb_arbiter.sv
// Register-file write-back arbiter: round-robin grant to one requester per cycle,
// registered RF write, and a pending-write scoreboard for decode RAW hazard checks.
module m_rf_wb_arbiter
  import m_rf_wb_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int XLEN = DEF_XLEN,
  parameter int AW   = DEF_AW
) (
  input logic              w_clk,
  input logic              w_rst_n,
  m_rf_wb_arbiter_if.slave bus
);

  localparam int IW   = $clog2(NREQ);
  localparam int NREG = 1 << AW;

  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_gnt_idx;
  logic            w_xfer;
  logic [AW-1:0]   w_sel_addr;
  logic [XLEN-1:0] w_sel_data;

  logic            r_we;
  logic [AW-1:0]   r_wa;
  logic [XLEN-1:0] r_wd;
  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_pending_nxt;

  m_rr_arb #(.N(NREQ)) u_rr_arb (
    .i_clk     (w_clk),
    .i_rst_n   (w_rst_n),
    .i_req     (bus.w_req_valid),
    .i_advance (w_xfer),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign bus.w_req_ready = w_gnt;
  assign w_xfer          = |w_gnt;
  assign w_sel_addr      = bus.w_req_addr[int'(w_gnt_idx)*AW +: AW];
  assign w_sel_data      = bus.w_req_data[int'(w_gnt_idx)*XLEN +: XLEN];

  // Writes to x0 are still accepted so the requester can retire, but never reach the RF.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_we <= 1'b0;
      r_wa <= '0;
      r_wd <= '0;
    end else begin
      r_we <= w_xfer && (w_sel_addr != AW'(REG_ZERO));
      if (w_xfer) begin
        r_wa <= w_sel_addr;
        r_wd <= w_sel_data;
      end
    end
  end

  // Issue is applied after the clear so a newer producer of the same register wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_xfer) begin
      w_pending_nxt[w_sel_addr] = 1'b0;
    end
    if (bus.w_iss_valid) begin
      w_pending_nxt[bus.w_iss_addr] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  // The in-flight term covers the cycle between the transfer and the RF write.
  assign bus.w_hz1 = (bus.w_ra1 != AW'(REG_ZERO)) &&
                     (r_pending[bus.w_ra1] || (r_we && (r_wa == bus.w_ra1)));
  assign bus.w_hz2 = (bus.w_ra2 != AW'(REG_ZERO)) &&
                     (r_pending[bus.w_ra2] || (r_we && (r_wa == bus.w_ra2)));

  assign bus.w_rf_we = r_we;
  assign bus.w_rf_wa = r_wa;
  assign bus.w_rf_wd = r_wd;

endmodule

// File: tb/tb_m_rf_wb_arbiter.sv
// Self-checking bench for m_rf_wb_arbiter: a per-cycle vector table with hand-derived
// grants/hazards, a queue of expected RF writes, and a hand-written mid-stream reset.
module tb_m_rf_wb_arbiter;
  import m_rf_wb_arbiter_pkg::*;

  localparam int NV = 25;

  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic        iss;
    logic [4:0]  issA;
    logic [4:0]  ra1, ra2;
    logic [2:0]  expReady;
    logic        expHz1, expHz2;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        chk;
  } rfexp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  vec_t   vecs [NV];
  rfexp_t expQ [$];
  logic [4:0]  lastWa;
  logic [31:0] lastWd;
  logic        lastOk;

  m_rf_wb_arbiter_if #(.NREQ(3), .XLEN(32), .AW(5)) bus ();

  m_rf_wb_arbiter dut (
    .w_clk   (clk),
    .w_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester data depends only on slot and address, so held requests stay stable.
  function automatic logic [31:0] dataFor(input int slot, input logic [4:0] a);
    return 32'hA000_0000 | (32'(slot) << 16) | {27'd0, a};
  endfunction

  function automatic vec_t mk(input logic [2:0] valid, input logic [4:0] a0, a1, a2,
                              input logic iss, input logic [4:0] issA, ra1, ra2,
                              input logic [2:0] er, input logic h1, h2);
    vec_t v;
    v.valid = valid; v.a0 = a0; v.a1 = a1; v.a2 = a2;
    v.d0 = dataFor(0, a0); v.d1 = dataFor(1, a1); v.d2 = dataFor(2, a2);
    v.iss = iss; v.issA = issA; v.ra1 = ra1; v.ra2 = ra2;
    v.expReady = er; v.expHz1 = h1; v.expHz2 = h2;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.w_req_valid = v.valid;
    bus.w_req_addr  = {v.a2, v.a1, v.a0};
    bus.w_req_data  = {v.d2, v.d1, v.d0};
    bus.w_iss_valid = v.iss;
    bus.w_iss_addr  = v.issA;
    bus.w_ra1       = v.ra1;
    bus.w_ra2       = v.ra2;
  endtask

  task automatic pushExpected(input vec_t v);
    rfexp_t e;
    logic [4:0]  a;
    logic [31:0] d;
    a = 5'd0;
    d = 32'd0;
    if (v.expReady != 3'b000) begin
      case (v.expReady)
        3'b001:  begin a = v.a0; d = v.d0; end
        3'b010:  begin a = v.a1; d = v.d1; end
        default: begin a = v.a2; d = v.d2; end
      endcase
      e.we  = (a != 5'd0);
      e.wa  = a;
      e.wd  = d;
      e.chk = (a != 5'd0);
      lastWa = a;
      lastWd = d;
      lastOk = (a != 5'd0);
    end else begin
      e.we  = 1'b0;
      e.wa  = lastWa;
      e.wd  = lastWd;
      e.chk = lastOk;
    end
    expQ.push_back(e);
  endtask

  task automatic popCompare(input int row);
    rfexp_t e;
    if (expQ.size() == 0) begin
      checkOutput($sformatf("row%0d_queue_nonempty", row), 64'd0, 64'd1);
    end else begin
      e = expQ.pop_front();
      checkOutput($sformatf("row%0d_we", row), 64'(bus.w_rf_we), 64'(e.we));
      if (e.chk) begin
        checkOutput($sformatf("row%0d_wa", row), 64'(bus.w_rf_wa), 64'(e.wa));
        checkOutput($sformatf("row%0d_wd", row), 64'(bus.w_rf_wd), 64'(e.wd));
      end
    end
  endtask

  initial begin
    vec_t idle;
    total  = 0;
    bad    = 0;
    lastWa = 5'd0;
    lastWd = 32'd0;
    lastOk = 1'b1;

    // Round-robin with all three held, then the pending/in-flight hazard window.
    vecs[0]  = mk(3'b111, 5'd1, 5'd2, 5'd3,  1'b0, 5'd0, 5'd1,  5'd2,  3'b001, 1'b0, 1'b0);
    vecs[1]  = mk(3'b111, 5'd1, 5'd2, 5'd3,  1'b0, 5'd0, 5'd1,  5'd2,  3'b010, 1'b1, 1'b0);
    vecs[2]  = mk(3'b111, 5'd1, 5'd2, 5'd3,  1'b0, 5'd0, 5'd1,  5'd2,  3'b100, 1'b0, 1'b1);
    vecs[3]  = mk(3'b111, 5'd1, 5'd2, 5'd3,  1'b0, 5'd0, 5'd1,  5'd2,  3'b001, 1'b0, 1'b0);
    vecs[4]  = mk(3'b000, 5'd0, 5'd0, 5'd0,  1'b0, 5'd0, 5'd1,  5'd3,  3'b000, 1'b1, 1'b0);
    vecs[5]  = mk(3'b000, 5'd0, 5'd0, 5'd0,  1'b1, 5'd5, 5'd5,  5'd1,  3'b000, 1'b0, 1'b0);
    vecs[6]  = mk(3'b000, 5'd0, 5'd0, 5'd0,  1'b0, 5'd0, 5'd5,  5'd0,  3'b000, 1'b1, 1'b0);
    vecs[7]  = mk(3'b010, 5'd0, 5'd5, 5'd0,  1'b0, 5'd0, 5'd5,  5'd6,  3'b010, 1'b1, 1'b0);
    vecs[8]  = mk(3'b000, 5'd0, 5'd0, 5'd0,  1'b0, 5'd0, 5'd5,  5'd5,  3'b000, 1'b1, 1'b1);
    vecs[9]  = mk(3'b000, 5'd0, 5'd0, 5'd0,  1'b0, 5'd0, 5'd5,  5'd5,  3'b000, 1'b0, 1'b0);
    // Issue and write-back of x7 in the same cycle: the issue wins.
    vecs[10] = mk(3'b100, 5'd0, 5'd0, 5'd7,  1'b1, 5'd7, 5'd7,  5'd5,  3'b100, 1'b0, 1'b0);
    vecs[11] = mk(3'b000, 5'd0, 5'd0, 5'd0,  1'b0, 5'd0, 5'd7,  5'd3,  3'b000, 1'b1, 1'b0);
    vecs[12] = mk(3'b000, 5'd0, 5'd0, 5'd0,  1'b0, 5'd0, 5'd7,  5'd7,  3'b000, 1'b1, 1'b1);
    vecs[13] = mk(3'b001, 5'd7, 5'd0, 5'd0,  1'b0, 5'd0, 5'd7,  5'd0,  3'b001, 1'b1, 1'b0);
    vecs[14] = mk(3'b000, 5'd0, 5'd0, 5'd0,  1'b0, 5'd0, 5'd7,  5'd2,  3'b000, 1'b1, 1'b0);
    vecs[15] = mk(3'b000, 5'd0, 5'd0, 5'd0,  1'b0, 5'd0, 5'd7,  5'd1,  3'b000, 1'b0, 1'b0);
    // x0 write and x0 issue are both harmless.
    vecs[16] = mk(3'b010, 5'd0, 5'd0, 5'd0,  1'b1, 5'd0, 5'd0,  5'd0,  3'b010, 1'b0, 1'b0);
    vecs[16].d1 = 32'hDEADBEEF;
    vecs[17] = mk(3'b000, 5'd0, 5'd0, 5'd0,  1'b0, 5'd0, 5'd0,  5'd7,  3'b000, 1'b0, 1'b0);
    vecs[18] = mk(3'b101, 5'd8, 5'd0, 5'd9,  1'b0, 5'd0, 5'd8,  5'd9,  3'b100, 1'b0, 1'b0);
    vecs[19] = mk(3'b001, 5'd8, 5'd0, 5'd0,  1'b0, 5'd0, 5'd8,  5'd9,  3'b001, 1'b0, 1'b1);
    vecs[20] = mk(3'b000, 5'd0, 5'd0, 5'd0,  1'b0, 5'd0, 5'd8,  5'd9,  3'b000, 1'b1, 1'b0);
    // Req2 held three cycles, req0 joining in the second.
    vecs[21] = mk(3'b100, 5'd0, 5'd0, 5'd10, 1'b0, 5'd0, 5'd10, 5'd0,  3'b100, 1'b0, 1'b0);
    vecs[22] = mk(3'b101, 5'd11, 5'd0, 5'd10, 1'b0, 5'd0, 5'd10, 5'd11, 3'b001, 1'b1, 1'b0);
    vecs[23] = mk(3'b100, 5'd0, 5'd0, 5'd10, 1'b0, 5'd0, 5'd10, 5'd11, 3'b100, 1'b0, 1'b1);
    vecs[24] = mk(3'b000, 5'd0, 5'd0, 5'd0,  1'b0, 5'd0, 5'd10, 5'd11, 3'b000, 1'b1, 1'b0);

    idle = mk(3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd5, 5'd1, 3'b000, 1'b0, 1'b0);
    applyStimulus(idle);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_we", 64'(bus.w_rf_we), 64'd0);
    checkOutput("reset_wa", 64'(bus.w_rf_wa), 64'd0);
    checkOutput("reset_wd", 64'(bus.w_rf_wd), 64'd0);
    checkOutput("reset_hz1", 64'(bus.w_hz1), 64'd0);
    checkOutput("reset_ready", 64'(bus.w_req_ready), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("row%0d_ready", i), 64'(bus.w_req_ready), 64'(vecs[i].expReady));
      checkOutput($sformatf("row%0d_hz1", i), 64'(bus.w_hz1), 64'(vecs[i].expHz1));
      checkOutput($sformatf("row%0d_hz2", i), 64'(bus.w_hz2), 64'(vecs[i].expHz2));
      pushExpected(vecs[i]);
      @(posedge clk);
      #1;
      popCompare(i);
    end
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);

    // Mid-stream reset: one write in flight, x12 pending, all requesters waiting.
    applyStimulus(mk(3'b010, 5'd0, 5'd13, 5'd0, 1'b1, 5'd12, 5'd12, 5'd13, 3'b010, 1'b0, 1'b0));
    @(negedge clk);
    checkOutput("pre_rst_ready", 64'(bus.w_req_ready), 64'b010);
    @(posedge clk);
    #1;
    checkOutput("pre_rst_we", 64'(bus.w_rf_we), 64'd1);
    checkOutput("pre_rst_wa", 64'(bus.w_rf_wa), 64'd13);
    checkOutput("pre_rst_hz1", 64'(bus.w_hz1), 64'd1);
    checkOutput("pre_rst_hz2", 64'(bus.w_hz2), 64'd1);
    applyStimulus(mk(3'b111, 5'd14, 5'd15, 5'd16, 1'b0, 5'd0, 5'd12, 5'd13, 3'b001, 1'b0, 1'b0));
    #1;
    checkOutput("pre_rst_rr_ready", 64'(bus.w_req_ready), 64'b100);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_we", 64'(bus.w_rf_we), 64'd0);
    checkOutput("rst_mid_ready", 64'(bus.w_req_ready), 64'b001);
    for (int r = 0; r < 32; r++) begin
      bus.w_ra1 = 5'(r);
      bus.w_ra2 = 5'(31 - r);
      #0.25;
      checkOutput($sformatf("rst_hz1_ra%0d", r), 64'(bus.w_hz1), 64'd0);
      checkOutput($sformatf("rst_hz2_ra%0d", 31 - r), 64'(bus.w_hz2), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_ready", 64'(bus.w_req_ready), 64'b001);
    @(posedge clk);
    #1;
    checkOutput("post_rst_we", 64'(bus.w_rf_we), 64'd1);
    checkOutput("post_rst_wa", 64'(bus.w_rf_wa), 64'd14);
    checkOutput("post_rst_wd", 64'(bus.w_rf_wd), 64'(dataFor(0, 5'd14)));
    applyStimulus(idle);
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
